// File: rtl/serial_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_gen
// Description : Shifts a captured pattern out MSB-first on `a`. Each bit is held
//               for BIT_CYCLES cycles, and the pattern is sent reps+1 times.
//               Define PATTERN_GEN_PARITY_EN to append an even-parity bit per pass.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_gen #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4,
  parameter int LEN_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       reps,
  output logic             a,
  output logic             bit_stb,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [3:0]       reps_q, reps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             stb_q, stb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_clamp;
`ifdef PATTERN_GEN_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             in_par_q, in_par_d;
`endif

  // Bit select without a wider-than-needed index into the pattern vector.
  function automatic logic pick(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (i == LEN_W'(k)) b = p[k];
    end
    return b;
  endfunction

`ifdef PATTERN_GEN_PARITY_EN
  function automatic logic low_parity(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] n);
    logic x;
    x = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (LEN_W'(k) < n) x = x ^ p[k];
    end
    return x;
  endfunction
`endif

  always_comb begin
    len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    idx_d     = idx_q;
    reps_d    = reps_q;
    cnt_d     = cnt_q;
    a_d       = 1'b0;
    stb_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef PATTERN_GEN_PARITY_EN
    par_bit_d = par_bit_q;
    in_par_d  = in_par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pat_d  = pattern;
          len_d  = len_clamp;
          reps_d = reps;
          cnt_d  = '0;
          if (len_clamp != '0) begin
            state_d = SEND;
            idx_d   = len_clamp - 1'b1;
            a_d     = pick(pattern, len_clamp - 1'b1);
            stb_d   = 1'b1;
            busy_d  = 1'b1;
`ifdef PATTERN_GEN_PARITY_EN
            par_bit_d = low_parity(pattern, len_clamp);
            in_par_d  = 1'b0;
`endif
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      SEND: begin
        busy_d = 1'b1;
        a_d    = a_q;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          // While the parity bit is out, idx_q is already 0, so this branch is skipped.
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
            a_d   = pick(pat_q, idx_q - 1'b1);
            stb_d = 1'b1;
`ifdef PATTERN_GEN_PARITY_EN
          end else if (!in_par_q) begin
            in_par_d = 1'b1;
            a_d      = par_bit_q;
            stb_d    = 1'b1;
`endif
          end else if (reps_q != 4'd0) begin
            reps_d = reps_q - 4'd1;
            idx_d  = len_q - 1'b1;
            a_d    = pick(pat_q, len_q - 1'b1);
            stb_d  = 1'b1;
`ifdef PATTERN_GEN_PARITY_EN
            in_par_d = 1'b0;
`endif
          end else begin
            state_d = FIN;
            busy_d  = 1'b0;
            a_d     = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      reps_q  <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PATTERN_GEN_PARITY_EN
      par_bit_q <= 1'b0;
      in_par_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      reps_q  <= reps_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PATTERN_GEN_PARITY_EN
      par_bit_q <= par_bit_d;
      in_par_q  <= in_par_d;
`endif
    end
  end

  assign a       = a_q;
  assign bit_stb = stb_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_pattern_gen
// Description : Bench for serial_pattern_gen; a per-cycle expected-output queue
//               built from the transmission rules, plus pinned literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_gen;

  localparam int WIDTH = 8;
  localparam int BC    = 4;
  localparam int SA    = 0;
  localparam int SSTB  = 1;
  localparam int SBUSY = 2;
  localparam int SDONE = 3;

  typedef struct packed {
    logic a;
    logic stb;
    logic busy;
    logic done;
  } out_t;

  typedef struct {
    int    c;
    int    sel;
    logic  v;
    string nm;
  } lit_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       a;
  logic       bit_stb;
  logic       busy;
  logic       done;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  out_t exp_q[$];
  lit_t lits[$];

  serial_pattern_gen #(
    .WIDTH      (WIDTH),
    .BIT_CYCLES (BC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .a       (a),
    .bit_stb (bit_stb),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output of every cycle of one accepted transmission, FIN included.
  task automatic enqueue(input logic [7:0] p, input int l, input int r);
    int   lc;
    out_t o;
    logic par;
    lc  = (l > WIDTH) ? WIDTH : l;
    par = 1'b0;
    for (int b = 0; b < lc; b++) par = par ^ p[b];
    if (lc > 0) begin
      for (int pass = 0; pass <= r; pass++) begin
        for (int b = lc - 1; b >= 0; b--) begin
          for (int c = 0; c < BC; c++) begin
            o = '{a: p[b], stb: (c == 0), busy: 1'b1, done: 1'b0};
            exp_q.push_back(o);
          end
        end
`ifdef PATTERN_GEN_PARITY_EN
        for (int c = 0; c < BC; c++) begin
          o = '{a: par, stb: (c == 0), busy: 1'b1, done: 1'b0};
          exp_q.push_back(o);
        end
`endif
      end
    end
    o = '{a: 1'b0, stb: 1'b0, busy: 1'b0, done: 1'b1};
    exp_q.push_back(o);
  endtask

  // Model: the entry for the ending cycle is retired; start is honoured only if that cycle was idle.
  always @(posedge clk) begin
    bit was_idle;
    was_idle = (exp_q.size() == 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (reset) exp_q.delete();
    else if (was_idle && start) enqueue(pattern, int'(len), int'(reps));
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    out_t e;
    out_t g;
    logic got;
    if (cyc > 0) begin
      e = (exp_q.size() > 0) ? exp_q[0] : '0;
      g = '{a: a, stb: bit_stb, busy: busy, done: done};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL cycle %0d {a,stb,busy,done}: got %b want %b", cyc, g, e);
      end
      for (int i = 0; i < lits.size(); i++) begin
        if (lits[i].c == cyc) begin
          case (lits[i].sel)
            SA:      got = a;
            SSTB:    got = bit_stb;
            SBUSY:   got = busy;
            default: got = done;
          endcase
          vectors++;
          if (got !== lits[i].v) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", lits[i].nm, got, lits[i].v);
          end
        end
      end
    end
  end

  task automatic lit(input int c, input int sel, input logic v, input string nm);
    lit_t t;
    t = '{c: c, sel: sel, v: v, nm: nm};
    lits.push_back(t);
  endtask

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; pattern = 8'h00; len = 4'd0; reps = 4'd0;
    lit(1, SA, 1'b0, "rst_a");
    lit(1, SSTB, 1'b0, "rst_stb");
    lit(2, SBUSY, 1'b0, "rst_busy");
    lit(2, SDONE, 1'b0, "rst_done");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 011, single pass; a start during SEND and changed inputs must be ignored
    @(negedge clk);
    pattern = 8'b0000_0011; len = 4'd3; reps = 4'd0; start = 1'b1; c0 = cyc;
    lit(c0 + 1, SA, 1'b0, "t1_a_c1");
    lit(c0 + 1, SSTB, 1'b1, "t1_stb_c1");
    lit(c0 + 2, SSTB, 1'b0, "t1_stb_c2");
    lit(c0 + 1, SBUSY, 1'b1, "t1_busy_c1");
    lit(c0 + 5, SA, 1'b1, "t1_a_c5");
    lit(c0 + 5, SSTB, 1'b1, "t1_stb_c5");
    lit(c0 + 9, SA, 1'b1, "t1_a_c9");
    lit(c0 + 12, SBUSY, 1'b1, "t1_busy_c12");
`ifdef PATTERN_GEN_PARITY_EN
    lit(c0 + 13, SA, 1'b0, "t1_parity_c13");
    lit(c0 + 17, SDONE, 1'b1, "t1_done_c17");
`else
    lit(c0 + 13, SDONE, 1'b1, "t1_done_c13");
    lit(c0 + 13, SBUSY, 1'b0, "t1_busy_c13");
`endif
    @(negedge clk); start = 1'b0; pattern = 8'hFF; len = 4'd7;
    repeat (2) @(negedge clk); start = 1'b1; pattern = 8'h00;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);

    // three passes back to back
    pattern = 8'b0000_0011; len = 4'd3; reps = 4'd2; start = 1'b1; c0 = cyc;
    lit(c0 + 13, SA, 1'b0, "t2_a_c13");
`ifndef PATTERN_GEN_PARITY_EN
    lit(c0 + 17, SA, 1'b1, "t2_a_c17");
    lit(c0 + 36, SBUSY, 1'b1, "t2_busy_c36");
    lit(c0 + 37, SDONE, 1'b1, "t2_done_c37");
`endif
    @(negedge clk); start = 1'b0; reps = 4'd0;
    repeat (60) @(negedge clk);

    // zero length
    len = 4'd0; start = 1'b1; c0 = cyc;
    lit(c0 + 1, SDONE, 1'b1, "t3_done_c1");
    lit(c0 + 1, SBUSY, 1'b0, "t3_busy_c1");
    lit(c0 + 1, SA, 1'b0, "t3_a_c1");
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);

    // length clamp
    pattern = 8'hA5; len = 4'd15; start = 1'b1; c0 = cyc;
    lit(c0 + 1, SA, 1'b1, "t4_a_c1");
    lit(c0 + 5, SA, 1'b0, "t4_a_c5");
    lit(c0 + 21, SA, 1'b1, "t4_a_c21");
    lit(c0 + 29, SA, 1'b1, "t4_a_c29");
`ifdef PATTERN_GEN_PARITY_EN
    lit(c0 + 33, SA, 1'b0, "t4_parity_c33");
    lit(c0 + 37, SDONE, 1'b1, "t4_done_c37");
`else
    lit(c0 + 33, SDONE, 1'b1, "t4_done_c33");
`endif
    @(negedge clk); start = 1'b0;
    repeat (45) @(negedge clk);

    // reset at cycle 6 aborts without done
    pattern = 8'b0000_0011; len = 4'd3; start = 1'b1; c0 = cyc;
    lit(c0 + 6, SBUSY, 1'b1, "t5_busy_c6");
    lit(c0 + 7, SBUSY, 1'b0, "t5_busy_c7");
    lit(c0 + 7, SA, 1'b0, "t5_a_c7");
    lit(c0 + 13, SDONE, 1'b0, "t5_nodone_c13");
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);

    // 111: parity bit is 1 when enabled, line idle otherwise
    pattern = 8'b0000_0111; len = 4'd3; start = 1'b1; c0 = cyc;
`ifdef PATTERN_GEN_PARITY_EN
    lit(c0 + 13, SA, 1'b1, "t6_parity_c13");
`else
    lit(c0 + 13, SA, 1'b0, "t6_a_c13");
`endif
    // held start re-triggers right after FIN
    repeat (40) @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);

    for (int i = 0; i < 2500; i++) begin
      start   = ($urandom_range(2, 0) == 0);
      pattern = 8'($urandom);
      len     = 4'($urandom_range(15, 0));
      reps    = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'($urandom_range(2, 0));
      reset   = ($urandom_range(149, 0) == 0);
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
